// File: rtl/fun_truth_scanner.sv
// Sweeps every input vector of an N_IN-input combinational block and captures its
// response into a packed truth table plus a ones-count.
module fun_truth_scanner #(
  parameter int N_IN   = 5,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 f_in,
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   truth_tbl,
  output logic [N_IN:0]        ones_cnt
);

  localparam int TBL_W  = 2**N_IN;
  localparam int ONES_W = N_IN + 1;
  localparam int CNT_W  = $clog2(SETTLE) + 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  LAST_VEC   = '1;

  typedef enum logic {IDLE, SCAN} state_e;

  state_e             state_q, state_d;
  logic [N_IN-1:0]    vec_q,   vec_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic [TBL_W-1:0]   tbl_q,   tbl_d;
  logic [ONES_W-1:0]  ones_q,  ones_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic               sample;
  logic               last_sample;

  assign sample      = (state_q == SCAN) && !abort && (cnt_q == '0);
  assign last_sample = sample && (vec_q == LAST_VEC);

  // NOTE: sequential state updates use <= so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tbl_q   <= '0;
      ones_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tbl_q   <= tbl_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && !abort) state_d = SCAN;
      SCAN: if (abort || last_sample) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every variable gets a hold/default value first so no path infers a latch.
  always_comb begin
    vec_d  = vec_q;
    busy_d = busy_q;
    done_d = 1'b0;
    tbl_d  = tbl_q;
    ones_d = ones_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          vec_d  = '0;
          tbl_d  = '0;
          ones_d = '0;
          cnt_d  = CNT_RELOAD;
          busy_d = 1'b1;
        end
      end
      SCAN: begin
        // Abort leaves the partial table and count visible for inspection.
        if (abort) begin
          busy_d = 1'b0;
          vec_d  = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          tbl_d[vec_q] = f_in;
          ones_d       = ones_q + ONES_W'(f_in);
          if (vec_q == LAST_VEC) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            vec_d  = '0;
          end else begin
            vec_d = vec_q + 1'b1;
            cnt_d = CNT_RELOAD;
          end
        end
      end
      default: ;
    endcase
  end

  assign vec_out   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign truth_tbl = tbl_q;
  assign ones_cnt  = ones_q;

endmodule

// File: tb/tb_fun_truth_scanner.sv
// Self-checking bench: two scanner instances (settle 1 and 3) each observe a
// function table; expected timing and results come from a cycle-count model.
module tb_fun_truth_scanner;

  localparam int SETTLE_OF [2] = '{1, 3};

  logic        clk;
  logic        rst_n;
  logic        start_s [2];
  logic        abort_s [2];
  logic        f_s     [2];
  logic [31:0] func_s  [2];
  logic [4:0]  vec_s   [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic [31:0] tbl_s   [2];
  logic [5:0]  ones_s  [2];

  int n_checks = 0;
  int n_errors = 0;

  // The "function block": a lookup into the currently selected truth table.
  assign f_s[0] = func_s[0][vec_s[0]];
  assign f_s[1] = func_s[1][vec_s[1]];

  fun_truth_scanner #(.N_IN(5), .SETTLE(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]), .f_in(f_s[0]),
    .vec_out(vec_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .truth_tbl(tbl_s[0]), .ones_cnt(ones_s[0])
  );

  fun_truth_scanner #(.N_IN(5), .SETTLE(3)) u_dut_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]), .f_in(f_s[1]),
    .vec_out(vec_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .truth_tbl(tbl_s[1]), .ones_cnt(ones_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input int s, input string tag);
    check($sformatf("%s s%0d vec", tag, s),  64'(vec_s[s]),  64'd0);
    check($sformatf("%s s%0d busy", tag, s), 64'(busy_s[s]), 64'd0);
    check($sformatf("%s s%0d done", tag, s), 64'(done_s[s]), 64'd0);
    check($sformatf("%s s%0d tbl", tag, s),  64'(tbl_s[s]),  64'd0);
    check($sformatf("%s s%0d ones", tag, s), 64'(ones_s[s]), 64'd0);
  endtask

  // One scan on instance s: vector k/settle is expected k cycles after the start
  // edge; abort_at >= 0 cancels while that vector is first driven.
  task automatic run_scan(input int s, input logic [31:0] fn, input int abort_at,
                          input bit hold);
    int          sv;
    logic [31:0] exp_tbl;
    sv         = SETTLE_OF[s];
    func_s[s]  = fn;
    start_s[s] = 1'b1;
    abort_s[s] = 1'b0;
    @(posedge clk); #1;
    if (!hold) start_s[s] = 1'b0;
    for (int k = 0; k < 32 * sv; k++) begin
      check($sformatf("s%0d vec k=%0d", sv, k),  64'(vec_s[s]),  64'(k / sv));
      check($sformatf("s%0d busy k=%0d", sv, k), 64'(busy_s[s]), 64'd1);
      check($sformatf("s%0d done k=%0d", sv, k), 64'(done_s[s]), 64'd0);
      if (abort_at >= 0 && k == abort_at * sv) begin
        abort_s[s] = 1'b1;
        @(posedge clk); #1;
        abort_s[s] = 1'b0;
        exp_tbl = '0;
        for (int i = 0; i < abort_at; i++) exp_tbl[i] = fn[i];
        check($sformatf("s%0d abort busy", sv), 64'(busy_s[s]), 64'd0);
        check($sformatf("s%0d abort vec", sv),  64'(vec_s[s]),  64'd0);
        check($sformatf("s%0d abort done", sv), 64'(done_s[s]), 64'd0);
        check($sformatf("s%0d abort tbl", sv),  64'(tbl_s[s]),  64'(exp_tbl));
        check($sformatf("s%0d abort ones", sv), 64'(ones_s[s]), 64'($countones(exp_tbl)));
        repeat (2) begin
          @(posedge clk); #1;
          check($sformatf("s%0d post-abort done", sv), 64'(done_s[s]), 64'd0);
          check($sformatf("s%0d post-abort busy", sv), 64'(busy_s[s]), 64'd0);
        end
        return;
      end
      @(posedge clk); #1;
    end
    check($sformatf("s%0d done pulse", sv), 64'(done_s[s]), 64'd1);
    check($sformatf("s%0d end busy", sv),   64'(busy_s[s]), 64'd0);
    check($sformatf("s%0d end vec", sv),    64'(vec_s[s]),  64'd0);
    check($sformatf("s%0d end tbl", sv),    64'(tbl_s[s]),  64'(fn));
    check($sformatf("s%0d end ones", sv),   64'(ones_s[s]), 64'($countones(fn)));
    if (!hold) begin
      @(posedge clk); #1;
      check($sformatf("s%0d done width", sv), 64'(done_s[s]), 64'd0);
      check($sformatf("s%0d tbl hold", sv),   64'(tbl_s[s]),  64'(fn));
      check($sformatf("s%0d ones hold", sv),  64'(ones_s[s]), 64'($countones(fn)));
    end
  endtask

  initial begin
    logic [31:0] fn_e, fn_a, fn_and, fn_r;
    int          s, ab;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      abort_s[i] = 1'b0;
      func_s[i]  = '0;
    end
    for (int i = 0; i < 32; i++) begin
      fn_e[i]   = (i % 2) == 1;
      fn_a[i]   = i >= 16;
      fn_and[i] = i == 31;
    end

    #12;
    check_zero(0, "reset");
    check_zero(1, "reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // f = e, settle 1; f = a&b&c&d&e, settle 3.
    run_scan(0, fn_e, -1, 1'b0);
    check("f=e tbl const", 64'(tbl_s[0]), 64'h0000_0000_AAAA_AAAA);
    run_scan(1, fn_and, -1, 1'b0);
    check("f=and tbl const", 64'(tbl_s[1]), 64'h0000_0000_8000_0000);

    // Start held high: three back-to-back scans, start ignored while busy.
    for (int n = 0; n < 3; n++) run_scan(0, fn_a, -1, 1'b1);
    start_s[0] = 1'b0;
    @(posedge clk); #1;
    check("hold stop busy", 64'(busy_s[0]), 64'd0);
    check("hold stop done", 64'(done_s[0]), 64'd0);
    check("f=a tbl const", 64'(tbl_s[0]), 64'h0000_0000_FFFF_0000);

    // Abort while vector 10 is driven with f = 1.
    run_scan(0, 32'hFFFF_FFFF, 10, 1'b0);
    check("abort tbl const", 64'(tbl_s[0]), 64'h0000_0000_0000_03FF);
    check("abort ones const", 64'(ones_s[0]), 64'd10);

    // start and abort together in IDLE: nothing moves.
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    check("st+ab busy", 64'(busy_s[0]), 64'd0);
    check("st+ab vec",  64'(vec_s[0]),  64'd0);
    check("st+ab done", 64'(done_s[0]), 64'd0);
    check("st+ab tbl",  64'(tbl_s[0]),  64'h3FF);
    check("st+ab ones", 64'(ones_s[0]), 64'd10);
    @(posedge clk); #1;
    check("st+ab busy later", 64'(busy_s[0]), 64'd0);
    fn_r = $urandom;
    run_scan(0, fn_r, -1, 1'b0);

    // Randomized functions, instances and abort points.
    repeat (8) begin
      s    = int'($urandom_range(0, 1));
      fn_r = $urandom;
      ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 31)) : -1;
      run_scan(s, fn_r, ab, 1'b0);
    end

    // Asynchronous reset in the middle of a scan, away from any clock edge.
    func_s[0]  = 32'hFFFF_FFFF;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pre-reset busy", 64'(busy_s[0]), 64'd1);
    #4;
    rst_n = 1'b0;
    #1;
    check_zero(0, "async reset");
    check_zero(1, "async reset");
    #2;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_zero(0, "after reset");
      check_zero(1, "after reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fun_truth_scanner.md
Name: fun_truth_scanner

Overview:
- Sequential stimulus/capture stage wrapped around the 5-input combinational function block.
- Drives the function's input vector {a,b,c,d,e} and consumes its output f.
- On a start request it sweeps all 2**N_IN input combinations in ascending order and samples f for each after a programmable settle time.
- Results: a packed truth table plus a ones-count, for on-chip self-check of the function.

Parameters:
- N_IN, 5: width of the driven input vector (a = MSB, e = LSB).
- SETTLE, 1: cycles between driving a vector and sampling f_in. Legal range is SETTLE >= 1; 0 is illegal.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  scan request, sampled on clk rising edge.
- abort  input  1  synchronous scan cancel.
- f_in  input  1  output f of the function block.
- vec_out  output  N_IN  driven vector {a,b,c,d,e}.
- busy  output  1  scan in progress.
- done  output  1  one-cycle completion pulse.
- truth_tbl  output  2**N_IN  bit i = f sampled with vec_out == i.
- ones_cnt  output  N_IN+1  number of vectors for which f_in was 1.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; vec_out=0, busy=0, done=0, truth_tbl=0, ones_cnt=0, settle counter=0. Outputs stay cleared until rst_n is high and a clock edge arrives.
- All outputs are registered. done is a registered pulse, high for exactly one cycle.
- States: IDLE, SCAN.
- IDLE, start=1 and abort=0 at an edge:
  - vec_out<=0, truth_tbl<=0, ones_cnt<=0, cnt<=SETTLE-1.
  - busy<=1, done<=0, go to SCAN.
- IDLE, otherwise: hold all outputs; done<=0.
- SCAN, abort=1 (highest priority):
  - go to IDLE; busy<=0, vec_out<=0, done stays 0.
  - No sample on that edge.
  - truth_tbl and ones_cnt keep their partial values.
- SCAN, cnt!=0: cnt<=cnt-1. Nothing else changes.
- SCAN, cnt==0:
  - truth_tbl[vec_out]<=f_in; ones_cnt<=ones_cnt+f_in.
  - If vec_out==2**N_IN-1: go to IDLE, busy<=0, done<=1, vec_out<=0.
  - Else: vec_out<=vec_out+1, cnt<=SETTLE-1.
- Timing, with E0 = the edge on which start is accepted:
  - Vector i is driven from edge E0+i*SETTLE.
  - Vector i is sampled at edge E0+(i+1)*SETTLE.
  - done is high in the cycle after edge E0+2**N_IN*SETTLE.
- start while busy=1 is ignored; no queuing.
- start high during the done cycle (state IDLE) is accepted, so back-to-back scans are legal.
- abort in IDLE has no effect. If start and abort are both high in IDLE, abort wins and no scan starts.
- truth_tbl and ones_cnt hold their values after done until the next accepted start or reset.
- Widths and arithmetic:
  - ones_cnt is N_IN+1 bits so the full count 2**N_IN fits (32 in 6 bits); no saturation is needed.
  - vec_out increments without wrap during a scan; the terminal vector is detected explicitly.
  - cnt width is clog2(SETTLE)+1.
- Reset asserted mid-scan clears everything immediately; no done is produced for the interrupted scan.

Test Plan:
- Reset: hold rst_n=0 mid-scan, asynchronously and not on an edge -> vec_out, busy, done, truth_tbl and ones_cnt read 0 immediately; after release, all stay 0 with start=0.
- SETTLE=1, f_in=vec_out[0] (e), start pulse at E0 -> vec_out steps 0..31, one per cycle; done high only in the cycle after E0+32; truth_tbl=32'hAAAA_AAAA; ones_cnt=16; busy low from E0+32.
- SETTLE=3, f_in = AND of all five bits -> each vector held 3 cycles; done in the cycle after E0+96; truth_tbl=32'h8000_0000; ones_cnt=1.
- start held high continuously, SETTLE=1, f_in=vec_out[4] (a) -> start is ignored while busy; done pulses every 33 cycles; each scan gives truth_tbl=32'hFFFF_0000 and ones_cnt=16.
- abort=1 on the edge where vec_out==10, SETTLE=1, f_in=1 -> next cycle busy=0 and vec_out=0; done never asserts; truth_tbl=32'h0000_03FF; ones_cnt=10.
- start and abort both high in IDLE -> busy stays 0 and outputs are unchanged. A subsequent start alone runs a full, correct scan.
